// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : Row-scanning matrix keypad reader. Drives one row low at a time,
//            samples synchronized active-low columns at the end of each row
//            slot, debounces over whole scans and reports single key presses
//            as a code with a one-cycle valid strobe and a held-down level.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 3,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] col_n,
  output logic [ROWS-1:0] row_n,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_down
);

  localparam int ROW_W = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  // Synchronizer and scan position
  logic [COLS-1:0]  col_s1;
  logic [COLS-1:0]  col_s2;
  logic [ROW_W-1:0] r;
  logic [DIV_W-1:0] d;

  // Per-scan accumulation
  logic [1:0]       hit_cnt;
  logic [3:0]       last_code;

  // Debounce state
  state_t           state;
  state_t           next_state;
  logic [3:0]       cand;
  logic [3:0]       next_cand;
  logic [3:0]       s;
  logic [3:0]       next_s;
  logic             accept;
  logic             release_evt;
  logic             accept_pend;
  logic             release_pend;

  // Combinational sample evaluation
  logic             sample;
  logic             scan_start;
  logic             scan_end;
  logic [1:0]       row_hits;
  logic [1:0]       col_idx;
  logic [3:0]       row_code;
  logic [2:0]       tot_sum;
  logic [1:0]       tot;
  logic [3:0]       new_code;
  logic             res_none;
  logic             res_one;

  assign sample     = (d == DIV_W'(SCAN_DIV - 1));
  assign scan_start = (r == '0) && (d == '0);
  assign scan_end   = sample && (r == ROW_W'(ROWS - 1));
  assign row_n      = ~(ROWS'(1) << r);

  // Two-flop synchronizer for the asynchronous column lines (idle high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  // Row divider and row index rotation; the row advances on the sample edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      d <= '0;
    end else if (sample) begin
      d <= '0;
      r <= (r == ROW_W'(ROWS - 1)) ? '0 : r + ROW_W'(1);
    end else begin
      d <= d + DIV_W'(1);
    end
  end

  // Count active columns in the current row and fold them into the scan total
  always_comb begin
    row_hits = 2'd0;
    col_idx  = 2'd0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_s2[c]) begin
        col_idx = 2'(c);
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
      end
    end
    row_code = 4'(r) * 4'(COLS) + 4'(col_idx);
    tot_sum  = {1'b0, hit_cnt} + {1'b0, row_hits};
    tot      = (tot_sum >= 3'd2) ? 2'd2 : tot_sum[1:0];
    new_code = (row_hits != 2'd0) ? row_code : last_code;
    res_none = (tot == 2'd0);
    res_one  = (tot == 2'd1);
  end

  // Per-scan hit accumulator, cleared at the start of every scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt   <= 2'd0;
      last_code <= 4'd0;
    end else if (scan_start) begin
      hit_cnt   <= 2'd0;
      last_code <= 4'd0;
    end else if (sample) begin
      hit_cnt   <= tot;
      last_code <= new_code;
    end
  end

  // Debounce state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cand         <= 4'd0;
      s            <= 4'd0;
      accept_pend  <= 1'b0;
      release_pend <= 1'b0;
    end else begin
      state        <= next_state;
      cand         <= next_cand;
      s            <= next_s;
      accept_pend  <= accept;
      release_pend <= release_evt;
    end
  end

  // Debounce next-state logic, evaluated only on scan-end edges
  always_comb begin
    next_state  = state;
    next_cand   = cand;
    next_s      = s;
    accept      = 1'b0;
    release_evt = 1'b0;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (res_one) begin
            next_cand = new_code;
            if (DEBOUNCE_SCANS == 1) begin
              accept     = 1'b1;
              next_state = HELD;
              next_s     = 4'd0;
            end else begin
              next_state = PRESS_DB;
              next_s     = 4'd1;
            end
          end
        end
        PRESS_DB: begin
          if (res_one && (new_code == cand)) begin
            if (s + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
              accept     = 1'b1;
              next_state = HELD;
              next_s     = 4'd0;
            end else begin
              next_s = s + 4'd1;
            end
          end else if (res_one) begin
            next_cand = new_code;
            next_s    = 4'd1;
          end else begin
            next_state = IDLE;
            next_s     = 4'd0;
          end
        end
        HELD: begin
          if (res_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              release_evt = 1'b1;
              next_state  = IDLE;
              next_s      = 4'd0;
            end else begin
              next_state = REL_DB;
              next_s     = 4'd1;
            end
          end
        end
        REL_DB: begin
          if (res_none) begin
            if (s + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
              release_evt = 1'b1;
              next_state  = IDLE;
              next_s      = 4'd0;
            end else begin
              next_s = s + 4'd1;
            end
          end else begin
            next_state = HELD;
            next_s     = 4'd0;
          end
        end
        default: begin
          next_state = IDLE;
          next_s     = 4'd0;
        end
      endcase
    end
  end

  // Output register: updates one cycle after the deciding scan-end edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= accept_pend;
      if (accept_pend) begin
        key_code <= cand;
        key_down <= 1'b1;
      end else if (release_pend) begin
        key_down <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Self-checking bench for keypad_scanner with a combinational
//            keypad model and a scan-level behavioural reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 3;
  localparam int SDIV = 4;
  localparam int DB   = 3;
  localparam int SCAN = ROWS * SDIV;

  logic            clk;
  logic            rst;
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic [3:0]      key_code;
  logic            key_valid;
  logic            key_down;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed-key matrix, bit index = row*COLS + col
  logic [ROWS*COLS-1:0] pressed;

  // Keypad: a column is pulled low when a pressed key sits on the active row
  always_comb begin
    col_n = '1;
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++)
        if (!row_n[rr] && pressed[rr*COLS+cc]) col_n[cc] = 1'b0;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n         = 0;
  logic [ROWS*COLS-1:0] cur_mask;

  // Reference state
  bit   held;
  int   run_code;
  int   run_len;
  bit   exp_valid, exp_down;
  logic [3:0] exp_code;
  bit   pend_valid, pend_rel;
  logic [3:0] pend_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
  endtask

  task automatic model_reset();
    held = 0; run_code = -1; run_len = 0;
    exp_valid = 0; exp_down = 0; exp_code = 4'd0;
    pend_valid = 0; pend_rel = 0; pend_code = 4'd0;
    n = 0;
  endtask

  // One full scan with the given pressed set: classify it and debounce
  task automatic model_scan(input logic [ROWS*COLS-1:0] mask);
    int cnt;
    int code;
    cnt  = $countones(mask);
    code = 0;
    for (int i = 0; i < ROWS*COLS; i++) if (mask[i]) code = i;
    if (!held) begin
      if (cnt == 1) begin
        if (run_code == code) run_len++;
        else begin run_code = code; run_len = 1; end
        if (run_len == DB) begin
          held = 1; run_len = 0; run_code = -1;
          pend_valid = 1; pend_code = 4'(code);
        end
      end else begin
        run_code = -1; run_len = 0;
      end
    end else begin
      if (cnt == 0) begin
        run_len++;
        if (run_len == DB) begin
          held = 0; run_len = 0; pend_rel = 1;
        end
      end else run_len = 0;
    end
  endtask

  task automatic step();
    logic [ROWS-1:0] exp_row;
    @(posedge clk);
    n++;
    if (n % SCAN == 1) begin
      exp_valid = pend_valid;
      if (pend_valid) begin exp_code = pend_code; exp_down = 1; end
      if (pend_rel) exp_down = 0;
      pend_valid = 0; pend_rel = 0;
    end else exp_valid = 0;
    @(negedge clk);
    exp_row = ~(ROWS'(1) << ((n / SDIV) % ROWS));
    check("row_n", 32'(row_n), 32'(exp_row));
    check("key_valid", 32'(key_valid), 32'(exp_valid));
    check("key_code", 32'(key_code), 32'(exp_code));
    check("key_down", 32'(key_down), 32'(exp_down));
    if (n % SCAN == 0) model_scan(cur_mask);
  endtask

  task automatic run_scans(input logic [ROWS*COLS-1:0] mask, input int count);
    for (int k = 0; k < count; k++) begin
      cur_mask = mask;
      pressed  = mask;
      repeat (SCAN) step();
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_row_n", 32'(row_n), 32'(4'b1110));
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_key_down", 32'(key_down), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic reset_mid(input logic [ROWS*COLS-1:0] mask, input int cycles);
    cur_mask = mask;
    pressed  = mask;
    repeat (cycles) step();
    do_reset();
  endtask

  function automatic logic [ROWS*COLS-1:0] rand_mask();
    int sel;
    int a, b;
    sel = int'($urandom_range(0, 99));
    if (sel < 40) return '0;
    a = int'($urandom_range(0, ROWS*COLS-1));
    if (sel < 85) return (ROWS*COLS)'(1) << a;
    b = (a + int'($urandom_range(1, ROWS*COLS-1))) % (ROWS*COLS);
    return ((ROWS*COLS)'(1) << a) | ((ROWS*COLS)'(1) << b);
  endfunction

  initial begin
    rst      = 1'b1;
    pressed  = '0;
    cur_mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Idle 64 cycles
    run_scans('0, 4);
    // Key (2,1) held 10 scans, then released
    run_scans(12'(1) << 7, 10);
    run_scans('0, 5);
    // Bounce on (0,0)
    run_scans(12'(1) << 0, 2);
    run_scans('0, 1);
    run_scans(12'(1) << 0, 2);
    run_scans('0, 4);
    // Two keys together
    run_scans((12'(1) << 3) | (12'(1) << 11), 6);
    run_scans('0, 3);
    // Reset during press debounce with (1,2) held, then fresh acceptance
    run_scans(12'(1) << 5, 2);
    reset_mid(12'(1) << 5, 5);
    run_scans(12'(1) << 5, 4);
    // Reset while a key is held
    reset_mid(12'(1) << 5, 9);
    run_scans('0, 4);

    // Randomized hold patterns with occasional mid-scan resets
    for (int i = 0; i < 40; i++) begin
      logic [ROWS*COLS-1:0] m;
      m = rand_mask();
      run_scans(m, int'($urandom_range(1, 5)));
      if ($urandom_range(0, 14) == 0) reset_mid(m, int'($urandom_range(1, SCAN-1)));
    end
    run_scans('0, 5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Row-scanning matrix keypad reader for the front-panel I/O path. It drives one keypad row low at a time in a fixed rotation and samples the active-low column lines. It debounces across whole scans and reports a single key press as a code with a one-cycle valid strobe plus a held level. It is the input-side counterpart of the display digit-multiplex counter: that block drives a multiplexed output matrix, and this block reads a multiplexed input matrix.

## Interface
- ROWS, default 4: number of keypad rows driven; 2..4.
- COLS, default 3: number of column inputs; 2..4. ROWS*COLS must be ≤ 16.
- SCAN_DIV, default 1000: clock cycles each row stays active; minimum 4.
- DEBOUNCE_SCANS, default 3: consecutive full scans needed to accept a press or a release; 1..15.

- clk  input  1: system clock; all state on rising edge.
- rst  input  1: asynchronous, active-high reset.
- col_n  input  COLS: column lines, active-low (pulled up externally), asynchronous to clk.
- row_n  output  ROWS: row drive, one-hot-low; bit r low means row r is active.
- key_code  output  4: code of the accepted key, row*COLS + col; holds its value until the next accepted press.
- key_valid  output  1: one-cycle pulse when a press is accepted.
- key_down  output  1: high from press acceptance until release acceptance.

## Operation
- col_n passes through a 2-flop synchronizer before any use.
- Scan rotation:
  - Row index r counts 0..ROWS-1 and wraps to 0.
  - Divider d counts 0..SCAN_DIV-1 within each row.
  - row_n = ~(1<<r).
  - Sample point: the edge where d == SCAN_DIV-1. Synchronized columns are sampled for row r there, then r advances.
- Per-scan accumulation, cleared at the start of each scan (r == 0, d == 0):
  - hit count, saturating at 2;
  - code of the last hit.
- Scan end is the sample edge of row ROWS-1. Its scan result is one of:
  - NONE: 0 hits.
  - ONE(code): exactly 1 hit.
  - MULTI: 2 or more hits.
- State machine, evaluated once per scan end; a stability counter s tracks consecutive matching scans:
  - IDLE
    - ONE(c): cand = c, s = 1, go to PRESS_DB. If DEBOUNCE_SCANS == 1, accept immediately instead.
    - NONE or MULTI: stay.
  - PRESS_DB
    - ONE(cand): s++. When s reaches DEBOUNCE_SCANS, accept: key_code = cand, pulse key_valid, set key_down, go to HELD.
    - ONE(other): cand = other, s = 1.
    - NONE or MULTI: go to IDLE, s = 0.
  - HELD
    - NONE: s = 1, go to REL_DB. If DEBOUNCE_SCANS == 1, release immediately instead.
    - ONE or MULTI, any code: stay. No new key_valid while held.
  - REL_DB
    - NONE: s++. When s reaches DEBOUNCE_SCANS, clear key_down and go to IDLE.
    - Anything else: back to HELD, s = 0.
- key_code is never changed by a release.

## Timing
- Reset values:
  - row_n = ~1 (row 0 active);
  - r = 0, d = 0;
  - key_code = 0, key_valid = 0, key_down = 0;
  - state IDLE, counters and accumulators 0.
- Reset mid-scan or mid-debounce abandons all progress immediately (asynchronous). No pulse is emitted.
- Scan period is ROWS*SCAN_DIV cycles. row_n changes on the edge following each sample edge.
- Column input to sample: a col_n change must be stable at least 2 cycles before the sample edge to be seen.
- key_valid, key_code and key_down update on the edge one cycle after the deciding scan-end edge. key_valid is high for exactly one cycle.
- Minimum press latency, measured from the first scan containing the key: DEBOUNCE_SCANS scan periods plus 1 cycle.
- Release clears key_down with the same latency structure.
- Bench keypad model: col_n[c] = ~(row_n[r]==0 && pressed(r,c)), purely combinational.

## Test plan
Parameters for all scenarios: ROWS=4, COLS=3, SCAN_DIV=4, DEBOUNCE_SCANS=3, giving a 16-cycle scan.
- Reset then idle for 64 cycles:
  - row_n cycles 1110, 1101, 1011, 0111, each held 4 cycles;
  - key_valid never asserts; key_code = 0; key_down = 0.
- Press key (2,1) from cycle 0 and hold for 10 scans:
  - exactly one key_valid pulse, with key_code = 7, after the 3rd complete scan containing the key;
  - key_down stays high while the key is held.
- Release key (2,1) after the previous scenario:
  - key_down falls after 3 consecutive empty scans;
  - key_code stays 7; no key_valid.
- Bounce: press (0,0) for 2 scans, release for 1, press for 2, then release:
  - no key_valid; key_down stays 0.
- Press (1,0) and (3,2) together for 6 scans:
  - MULTI every scan; no key_valid.
- Assert rst during PRESS_DB with key (1,2) held, after 2 scans:
  - all outputs return to reset values at once;
  - after release of rst, key_valid with key_code = 5 comes only after 3 fresh full scans.
